tc_bcd_conv: RTL and testbench
==============================

Name: tc_bcd_conv

Overview:
- Sequential binary-to-BCD converter directly downstream of the thermocouple temperature calculator.
- Takes the 20-bit temperature word (units of ~0.01 °C) together with its one-cycle done strobe and produces packed BCD digits for the display/UART formatter.
- Uses shift-and-add-3 (double dabble), one input bit per clock, so area stays small on the tile.

Parameters:
- WIDTH, 20, bit width of binary input.
- DIGITS, 7, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1. This is checked by an elaboration-time assertion.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  one-cycle strobe, driven by the upstream done pulse
- i_bin  input  WIDTH  binary value, sampled only when i_start is accepted
- o_bcd  output  4*DIGITS  packed BCD, most significant digit in the top nibble
- o_done  output  1  one-cycle pulse, high when o_bcd has just been updated
- o_busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, shift register=0, bit counter=0, o_bcd=0, o_done=0, o_busy=0. Reset has priority over every other event.
- States: IDLE, SHIFT. Encodings are defined in the package. Any illegal state returns to IDLE on the next edge.
- IDLE, i_start=1 at edge E0:
  - Load bin register with i_bin; clear the BCD scratch register.
  - Set counter=WIDTH; go to SHIFT; o_busy<=1.
- IDLE, i_start=0: hold; o_bcd keeps its last value.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (combinational).
  - Then shift {scratch, bin} left by one bit; decrement counter.
- SHIFT, edge where the counter goes 1->0 (edge E_WIDTH):
  - o_bcd <= final scratch value.
  - o_done <= 1 for exactly one cycle; o_busy <= 0; state=IDLE.
- Latency: o_done is high in the cycle after E_WIDTH, i.e. WIDTH clocks after the start edge (20 cycles by default). o_busy is high for exactly WIDTH cycles.
- o_done defaults to 0 on every edge unless it is being set.
- o_bcd changes only at the completion edge (and at reset). No intermediate values are ever visible.
- i_start while o_busy=1: ignored entirely. There is no queueing, and the conversion in flight is unaffected.
- i_start in the cycle o_done is high: the block is already in IDLE, so the start is accepted. Back-to-back throughput is one conversion per WIDTH+1 cycles.
- Reset during SHIFT: the conversion is aborted, no o_done is produced, and o_bcd=0.
- Arithmetic:
  - The add-3 operates on 4-bit digits and never carries between digits.
  - The scratch register is 4*DIGITS bits wide. The top bits cannot overflow given the parameter constraint.
- i_bin is don't-care except on the accepted start cycle.

Decomposition:
- Shared package tc_pkg holds:
  - the state enum/localparams for IDLE and SHIFT;
  - TC_TEMP_W=20, which is shared with the calculator output width;
  - TC_BCD_DIGITS=7.
- One combinational sub-module, tc_bcd_digit_adj: 4-bit in, 4-bit out, adds 3 if the input is >=5. It is instantiated DIGITS times via generate.

Test Plan:
- Reset then idle for 30 cycles -> o_bcd=0x0000000, o_done never high, o_busy=0.
- i_start with i_bin=137204 -> o_busy high for 20 cycles; o_done pulses exactly 20 cycles after the start edge; o_bcd=0x0137204.
- i_bin=0, then 1048575 (all ones), then 99999 -> o_bcd=0x0000000, 0x1048575, 0x0099999 respectively.
- Start with 33536, then pulse i_start with 65924 on cycle 5 of busy -> only one o_done; o_bcd=0x0033536. Then start 65924 in the o_done cycle -> second o_done 20 cycles later with o_bcd=0x0065924.
- Start with 31825, assert i_rst at busy cycle 10 -> no o_done, o_bcd=0, o_busy=0. A following start with 62783 completes normally with o_bcd=0x0062783.
- Random sweep (1000 values, back-to-back starts on each o_done) compared against a reference model -> every result matches and o_done count equals start count.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared thermocouple-chain definitions: temperature word width, display digit
// count and the BCD converter's state encoding.
package tc_pkg;

  localparam int TC_TEMP_W     = 20;
  localparam int TC_BCD_DIGITS = 7;

  // One-hot so that any corrupted state lands in the default branch.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_SHIFT = 2'b10
  } bcd_state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/tc_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries into the next digit.
module tc_bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/tc_bcd_conv.sv
// Sequential binary-to-BCD converter for the temperature word; shifts one input
// bit per clock and publishes the full digit set only when the conversion ends.
module tc_bcd_conv
  import tc_pkg::*;
#(
  parameter int WIDTH  = TC_TEMP_W,
  parameter int DIGITS = TC_BCD_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
    $fatal(1, "tc_bcd_conv: DIGITS too small to hold 2^WIDTH-1");
  end

  bcd_state_t          state;
  logic [WIDTH-1:0]    bin_reg;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adj;
  logic [BCD_W-1:0]    shifted_bcd;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    bcd;
  logic                done;
  logic                busy;
  logic                unused_adj_msb;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    tc_bcd_digit_adj u_adj (
      .digit (scratch[4*d +: 4]),
      .adj   (adj[4*d +: 4])
    );
  end

  // The top scratch bit after adjustment is always shifted out as zero given
  // the DIGITS/WIDTH relationship, so it is dropped here.
  assign shifted_bcd    = {adj[BCD_W-2:0], bin_reg[WIDTH-1]};
  assign unused_adj_msb = adj[BCD_W-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      bin_reg <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            bin_reg <= i_bin;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= shifted_bcd;
          bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd   <= shifted_bcd;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_bcd  = bcd;
  assign o_done = done;
  assign o_busy = busy;

endmodule

// File: tb/tb_tc_bcd_conv.sv
// Scoreboard bench for tc_bcd_conv: expected BCD words are queued at issue time
// and a monitor compares them whenever o_done is seen.
module tb_tc_bcd_conv;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 7;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     bin;
  logic [4*DIGITS-1:0]  bcd;
  logic                 done;
  logic                 busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int accepted = 0;
  bit mon_en = 0;
  logic [4*DIGITS-1:0] exp_q[$];
  logic [4*DIGITS-1:0] bcd_model = '0;

  tc_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_bin   (bin),
    .o_bcd   (bcd),
    .o_done  (done),
    .o_busy  (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Decimal digits by plain division, least significant digit in the low nibble.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample per cycle, 1 ns after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          bcd_model = exp_q.pop_front();
          check("bcd_result", 32'(bcd), 32'(bcd_model));
        end
      end else begin
        check("bcd_hold", 32'(bcd), 32'(bcd_model));
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    bcd_model = '0;
    @(negedge clk);
    rst = 0;
  endtask

  // Drives a one-cycle start; returns with the start edge just behind us.
  task automatic issue(input int unsigned v, input bit expect_accept);
    @(negedge clk);
    start = 1;
    bin = WIDTH'(v);
    if (expect_accept) begin
      exp_q.push_back(ref_bcd(v));
      accepted++;
    end
    @(negedge clk);
    start = 0;
    bin = WIDTH'($urandom);
  endtask

  // Counts cycles from the start edge until o_done; also counts busy cycles.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) return;
      if (busy) busy_cycles++;
    end
    check("done_timeout", 32'(cycles), 32'(WIDTH));
  endtask

  int cyc, bcyc, dc0;
  int unsigned v;

  initial begin
    rst = 1;
    start = 0;
    bin = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    mon_en = 1;

    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) check("idle_quiet", {30'd0, done, busy}, 32'd0);
    end
    check("idle_bcd", 32'(bcd), 32'd0);

    // Directed value: latency and busy width.
    issue(137204, 1);
    wait_done(cyc, bcyc);
    check("latency", 32'(cyc), 32'(WIDTH));
    check("busy_cycles", 32'(bcyc), 32'(WIDTH));
    check("bcd_137204", 32'(bcd), 32'h0137204);

    issue(0, 1);       wait_done(cyc, bcyc);
    check("bcd_zero", 32'(bcd), 32'h0000000);
    issue(1048575, 1); wait_done(cyc, bcyc);
    check("bcd_allones", 32'(bcd), 32'h1048575);
    issue(99999, 1);   wait_done(cyc, bcyc);
    check("bcd_99999", 32'(bcd), 32'h0099999);

    // Start during busy is ignored; start in the done cycle is accepted.
    dc0 = done_cnt;
    issue(33536, 1);
    repeat (3) @(negedge clk);
    start = 1;
    bin = WIDTH'(65924);
    @(negedge clk);
    start = 0;
    wait_done(cyc, bcyc);
    check("ignored_start_latency", 32'(cyc), 32'(WIDTH - 4));
    check("bcd_33536", 32'(bcd), 32'h0033536);
    issue(65924, 1);
    wait_done(cyc, bcyc);
    check("b2b_latency", 32'(cyc), 32'(WIDTH));
    check("bcd_65924", 32'(bcd), 32'h0065924);
    check("done_count_b2b", 32'(done_cnt - dc0), 32'd2);

    // Reset mid-conversion aborts it.
    dc0 = done_cnt;
    issue(31825, 1);
    repeat (8) @(negedge clk);
    accepted--;
    apply_reset();
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    issue(62783, 1);
    wait_done(cyc, bcyc);
    check("bcd_62783", 32'(bcd), 32'h0062783);

    // Random back-to-back sweep.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       v = 0;
        1:       v = (1 << WIDTH) - 1;
        default: v = $urandom_range(0, (1 << WIDTH) - 1);
      endcase
      issue(v, 1);
      wait_done(cyc, bcyc);
      if (cyc != WIDTH) check("sweep_latency", 32'(cyc), 32'(WIDTH));
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_count_total", 32'(done_cnt), 32'(accepted));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
